mac_pe: RTL

Parametrised systolic processing element: the next-generation tile of the matrix-multiply array. Forwards operands right and down with valid qualification and accumulates signed products only on qualified beats. Closes a dot-product tile on a `last` marker into a held result register, double-buffered so the next tile streams with no bubble. Adds optional saturation, overflow reporting and an operand-mismatch error flag.

---
 rtl/mac_pe.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mac_pe.sv
// Systolic multiply-accumulate processing element.
// Operands are forwarded right and down with one cycle of latency. Signed
// products are accumulated on beats where both operands are valid. A beat
// marked last closes the tile into a held result register, so the next tile
// can start on the following cycle. Accumulation either saturates or wraps on
// overflow, and a sticky error flag records beats where only one operand was
// valid.
module mac_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 21,
    parameter bit SAT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] up_in,
    input  logic              up_valid_in,
    input  logic [DATA_W-1:0] left_in,
    input  logic              left_valid_in,
    input  logic              left_last_in,
    input  logic              clr,
    output logic [DATA_W-1:0] up_out,
    output logic              up_valid_out,
    output logic [DATA_W-1:0] left_out,
    output logic              left_valid_out,
    output logic              left_last_out,
    output logic [ACC_W-1:0]  res_out,
    output logic              res_valid,
    output logic              res_ovf,
    output logic              err
);

    localparam int PROD_W = 2 * DATA_W;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0]         acc_reg;
    logic [ACC_W-1:0]         acc_next;
    logic                     tovf_reg;
    logic                     tovf_next;

    logic                     fire;
    logic                     mismatch;
    logic                     capture;
    logic signed [PROD_W-1:0] prod;
    logic [ACC_W:0]           prod_ext;
    logic [ACC_W:0]           base_ext;
    logic [ACC_W:0]           sum_ext;
    logic                     ovf;
    logic                     tovf_base;
    logic [ACC_W-1:0]         acc_val;

    assign fire     = up_valid_in & left_valid_in;
    assign mismatch = up_valid_in ^ left_valid_in;

    // Full-precision signed product, sign-extended to one bit wider than the
    // accumulator so overflow shows up as disagreement of the top two bits.
    assign prod     = $signed(up_in) * $signed(left_in);
    assign prod_ext = {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};

    // A clear on a fire beat makes that beat the first of a fresh tile.
    assign base_ext  = clr ? '0 : {acc_reg[ACC_W-1], acc_reg};
    assign tovf_base = clr ? 1'b0 : tovf_reg;

    assign sum_ext = base_ext + prod_ext;
    assign ovf     = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];

    generate
        if (SAT_EN) begin : gen_sat
            // Clamp toward the sign of the true (wide) sum.
            assign acc_val = ovf ? (sum_ext[ACC_W] ? ACC_MIN : ACC_MAX)
                                 : sum_ext[ACC_W-1:0];
        end else begin : gen_wrap
            // Two's-complement wrap: simply drop the extra top bit.
            assign acc_val = sum_ext[ACC_W-1:0];
        end
    endgenerate

    // Next accumulator / tile-overflow state and the capture decision.
    always_comb begin
        acc_next  = acc_reg;
        tovf_next = tovf_reg;
        capture   = 1'b0;
        if (fire) begin
            if (left_last_in) begin
                capture   = 1'b1;
                acc_next  = '0;
                tovf_next = 1'b0;
            end else begin
                acc_next  = acc_val;
                tovf_next = tovf_base | ovf;
            end
        end else if (clr) begin
            acc_next  = '0;
            tovf_next = 1'b0;
        end
    end

    // State, forwarding registers, result register and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            up_out         <= '0;
            up_valid_out   <= 1'b0;
            left_out       <= '0;
            left_valid_out <= 1'b0;
            left_last_out  <= 1'b0;
            acc_reg        <= '0;
            tovf_reg       <= 1'b0;
            res_out        <= '0;
            res_valid      <= 1'b0;
            res_ovf        <= 1'b0;
            err            <= 1'b0;
        end else begin
            up_out         <= up_in;
            up_valid_out   <= up_valid_in;
            left_out       <= left_in;
            left_valid_out <= left_valid_in;
            left_last_out  <= left_last_in;
            acc_reg        <= acc_next;
            tovf_reg       <= tovf_next;
            res_valid      <= capture;
            if (capture) begin
                res_out <= acc_val;
                res_ovf <= tovf_base | ovf;
            end
            if (mismatch) begin
                err <= 1'b1;
            end
        end
    end

endmodule
